dmem_lsu: RTL and testbench

Parametrised RV32I data memory with a load/store unit front end, the next generation of the single-cycle DMEM. Supports the byte, halfword and word access types of LB/LH/LW/LBU/LHU/SB/SH/SW. Detects misaligned, out-of-range and illegal accesses. Models a configurable access latency behind a req/ack handshake, so the core's MEM stage can be exercised against slow memory.

---
 rtl/dmem_lsu_if.sv | 31 +++
 rtl/dmem_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Core-to-data-memory bus for dmem_lsu.
//   req      access request (sampled only while the memory is idle)
//   MemRW    1 = store, 0 = load
//   funct3   RV32I access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr     byte address
//   data_in  store data, LSB-aligned
//   data_out load result, extended to 32 bits
//   busy     access in progress
//   ack      one-cycle completion pulse
//   fault    valid with ack; access rejected
interface dmem_lsu_if;
    logic        req;
    logic        MemRW;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        ack;
    logic        fault;

    modport master (
        output req, MemRW, funct3, addr, data_in,
        input  data_out, busy, ack, fault
    );

    modport slave (
        input  req, MemRW, funct3, addr, data_in,
        output data_out, busy, ack, fault
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I data memory with load/store unit front end and configurable latency.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (memory contents are kept)
//   bus  dmem_lsu_if slave: req/MemRW/funct3/addr/data_in in,
//        data_out/busy/ack/fault out (all registered)
// Parameters: DEPTH words of 32 bits (power of two, >= 4),
//             LATENCY cycles from accept edge to completing edge (1..15).
module dmem_lsu #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned AW    = IDX_W + 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_complete;
    logic               w_illegal;

    logic               r_rw;
    logic [2:0]         r_funct3;
    logic [AW-1:0]      r_addr;
    logic [31:0]        r_wdata;

    logic [31:0]        r_data_out;
    logic               r_busy;
    logic               r_ack;
    logic               r_fault;

    logic [31:0]        r_mem [DEPTH];
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic               w_we;

    // Legality of the request presented on the bus (checked at accept).
    always_comb begin
        w_illegal = 1'b0;
        case (bus.funct3)
            F_B:     w_illegal = 1'b0;
            F_H:     w_illegal = bus.addr[0];
            F_W:     w_illegal = |bus.addr[1:0];
            F_BU:    w_illegal = bus.MemRW;
            F_HU:    w_illegal = bus.MemRW | bus.addr[0];
            default: w_illegal = 1'b1;
        endcase
        // Word index beyond DEPTH: any address bit above the array is set.
        if (|bus.addr[31:AW]) begin
            w_illegal = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept = 1'b1;
                    if (w_illegal) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_DONE;
                    w_complete  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_ack   <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_rw     <= bus.MemRW;
                r_funct3 <= bus.funct3;
                r_addr   <= bus.addr[AW-1:0];
                r_wdata  <= bus.data_in;
                if (w_illegal) begin
                    r_fault    <= 1'b1;
                    r_data_out <= '0;
                end
            end
            if (w_complete) begin
                r_fault <= 1'b0;
                if (!r_rw) begin
                    r_data_out <= w_load;
                end
            end
        end
    end

    // Load path: lane select and extension from the latched request.
    always_comb begin
        w_idx  = r_addr[AW-1:2];
        w_word = r_mem[w_idx];
        w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_funct3)
            F_B:     w_load = {{24{w_byte[7]}}, w_byte};
            F_H:     w_load = {{16{w_half[15]}}, w_half};
            F_BU:    w_load = {24'h0, w_byte};
            F_HU:    w_load = {16'h0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store path: replicate data across lanes, enable only addressed bytes.
    always_comb begin
        case (r_funct3[1:0])
            2'd0: begin
                w_wlanes = {4{r_wdata[7:0]}};
                w_be     = 4'b0001 << r_addr[1:0];
            end
            2'd1: begin
                w_wlanes = {2{r_wdata[15:0]}};
                w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wlanes = r_wdata;
                w_be     = 4'b1111;
            end
        endcase
        // rst gating drops a store whose completing edge coincides with reset.
        w_we = w_complete & r_rw & ~rst;
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.busy     = r_busy;
    assign bus.ack      = r_ack;
    assign bus.fault    = r_fault;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (LATENCY 1, 3, 4) share one stimulus bus
// with per-instance req gating; results are checked against a byte-level model.
module tb_dmem_lsu;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_v = '0;
    logic        tb_rw = 1'b0;
    logic [2:0]  tb_f3 = '0;
    logic [31:0] tb_addr = '0;
    logic [31:0] tb_wdata = '0;

    always #5 clk = ~clk;

    dmem_lsu_if if_l1 ();
    dmem_lsu_if if_l3 ();
    dmem_lsu_if if_l4 ();

    assign if_l1.req = req_v[0];
    assign if_l3.req = req_v[1];
    assign if_l4.req = req_v[2];
    assign if_l1.MemRW = tb_rw;
    assign if_l3.MemRW = tb_rw;
    assign if_l4.MemRW = tb_rw;
    assign if_l1.funct3 = tb_f3;
    assign if_l3.funct3 = tb_f3;
    assign if_l4.funct3 = tb_f3;
    assign if_l1.addr = tb_addr;
    assign if_l3.addr = tb_addr;
    assign if_l4.addr = tb_addr;
    assign if_l1.data_in = tb_wdata;
    assign if_l3.data_in = tb_wdata;
    assign if_l4.data_in = tb_wdata;

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3));
    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if_l4));

    logic [2:0]  o_ack, o_busy, o_fault;
    logic [31:0] o_dout [3];
    assign o_ack   = {if_l4.ack, if_l3.ack, if_l1.ack};
    assign o_busy  = {if_l4.busy, if_l3.busy, if_l1.busy};
    assign o_fault = {if_l4.fault, if_l3.fault, if_l1.fault};
    assign o_dout[0] = if_l1.data_out;
    assign o_dout[1] = if_l3.data_out;
    assign o_dout[2] = if_l4.data_out;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl [256];
    logic [31:0] exp_dout [3];

    typedef struct {
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_f;
    } vec_t;

    vec_t tab [19];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d got=%h exp=%h t=%0t", nm, lat_of(k), got, exp, $time);
        end
    endtask

    // Byte-addressed reference: size from funct3, arithmetic sign extension.
    task automatic model_access(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rdata, output logic flt);
        int     size;
        longint v;
        case (f3 & 3'd3)
            3'd0:    size = 1;
            3'd1:    size = 2;
            default: size = 4;
        endcase
        flt = (f3 == 3'd3) || (f3 >= 3'd6) || (rw && f3 >= 3'd4)
              || ((a % size) != 0) || ((a / 4) >= DEPTH);
        rdata = '0;
        if (!flt) begin
            if (rw) begin
                for (int i = 0; i < size; i++) mdl[a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(mdl[a + i]) << (8 * i);
                if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v -= longint'(1) << (8 * size);
                rdata = v[31:0];
            end
        end
    endtask

    // One access on the selected instances; checks every cycle until idle.
    task automatic run_access(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] mask,
                              input logic use_tab, input logic [31:0] tab_d, input logic tab_f);
        logic [31:0] md, ed;
        logic        mf, ef;
        int          dk;
        model_access(rw, f3, a, wd, md, mf);
        ef = use_tab ? tab_f : mf;
        ed = use_tab ? tab_d : md;
        @(negedge clk);
        tb_rw = rw; tb_f3 = f3; tb_addr = a; tb_wdata = wd; req_v = mask;
        @(posedge clk); #1;
        req_v = '0;
        tb_addr = $urandom; tb_wdata = $urandom; tb_rw = 1'($urandom); tb_f3 = 3'($urandom);
        for (int c = 0; c <= 5; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    dk = ef ? 0 : lat_of(k);
                    if (c <= dk + 1)
                        chk("busy_ack", k, {30'b0, o_busy[k], o_ack[k]},
                            {30'b0, (c <= dk), (c == dk)});
                    if (c == dk) begin
                        chk("fault", k, {31'b0, o_fault[k]}, {31'b0, ef});
                        if (ef) exp_dout[k] = '0;
                        else if (!rw) exp_dout[k] = ed;
                        chk("data_out", k, o_dout[k], exp_dout[k]);
                    end
                end
            end
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [31:0] md, a;
        logic        mf, rw;
        logic [2:0]  f3;
        logic [31:0] hist [24];
        int          r;

        tab[0]  = '{1'b1, 3'd2, 32'h4,  32'd55,        32'h0,        1'b0};
        tab[1]  = '{1'b0, 3'd2, 32'h4,  32'h0,         32'd55,       1'b0};
        tab[2]  = '{1'b1, 3'd2, 32'h0,  32'h11223344,  32'h0,        1'b0};
        tab[3]  = '{1'b1, 3'd0, 32'h1,  32'h000000AA,  32'h0,        1'b0};
        tab[4]  = '{1'b1, 3'd1, 32'h2,  32'h0000BEEF,  32'h0,        1'b0};
        tab[5]  = '{1'b0, 3'd2, 32'h0,  32'h0,         32'hBEEFAA44, 1'b0};
        tab[6]  = '{1'b1, 3'd2, 32'h10, 32'h80FF7F01,  32'h0,        1'b0};
        tab[7]  = '{1'b0, 3'd0, 32'h11, 32'h0,         32'h0000007F, 1'b0};
        tab[8]  = '{1'b0, 3'd0, 32'h12, 32'h0,         32'hFFFFFFFF, 1'b0};
        tab[9]  = '{1'b0, 3'd4, 32'h13, 32'h0,         32'h00000080, 1'b0};
        tab[10] = '{1'b0, 3'd1, 32'h12, 32'h0,         32'hFFFF80FF, 1'b0};
        tab[11] = '{1'b0, 3'd5, 32'h12, 32'h0,         32'h000080FF, 1'b0};
        tab[12] = '{1'b0, 3'd2, 32'h2,  32'h0,         32'h0,        1'b1};
        tab[13] = '{1'b1, 3'd1, 32'h1,  32'hFFFFFFFF,  32'h0,        1'b1};
        tab[14] = '{1'b1, 3'd2, 32'(4 * DEPTH), 32'h12345678, 32'h0, 1'b1};
        tab[15] = '{1'b1, 3'd5, 32'h0,  32'hFFFFFFFF,  32'h0,        1'b1};
        tab[16] = '{1'b0, 3'd3, 32'h0,  32'h0,         32'h0,        1'b1};
        tab[17] = '{1'b0, 3'd2, 32'h0,  32'h0,         32'hBEEFAA44, 1'b0};
        tab[18] = '{1'b0, 3'd2, 32'h4,  32'h0,         32'd55,       1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_flags", k, {29'b0, o_busy[k], o_ack[k], o_fault[k]}, 32'h0);
            chk("rst_dout", k, o_dout[k], 32'h0);
            exp_dout[k] = '0;
        end
        @(negedge clk);
        rst = 1'b0;

        // Prefill words 0..63 with random data.
        for (int w = 0; w < 64; w++)
            run_access(1'b1, 3'd2, 32'(w * 4), $urandom, 3'b111, 1'b0, 32'h0, 1'b0);

        // Directed vectors.
        for (int i = 0; i < 19; i++)
            run_access(tab[i].rw, tab[i].f3, tab[i].addr, tab[i].wdata, 3'b111,
                       1'b1, tab[i].exp_d, tab[i].exp_f);

        // Reset mid-WAIT of a store on the LATENCY=3 instance drops the store.
        @(negedge clk);
        tb_rw = 1'b1; tb_f3 = 3'd2; tb_addr = 32'h8; tb_wdata = 32'hDEADBEEF; req_v = 3'b010;
        @(posedge clk); #1;
        req_v = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_flags", k, {29'b0, o_busy[k], o_ack[k], o_fault[k]}, 32'h0);
            chk("async_rst_dout", k, o_dout[k], 32'h0);
            exp_dout[k] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        run_access(1'b0, 3'd2, 32'h8, 32'h0, 3'b111, 1'b0, 32'h0, 1'b0);

        // req held high on the LATENCY=4 instance with addr changing every cycle.
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            if (t < 20) begin
                req_v = 3'b100; tb_rw = 1'b0; tb_f3 = 3'd2;
                tb_addr = 32'($urandom_range(0, 63)) << 2;
            end else begin
                req_v = '0;
            end
            hist[t] = tb_addr;
            @(posedge clk); #1;
            chk("held_busy_ack", 2, {30'b0, o_busy[2], o_ack[2]},
                {30'b0, ((t % 6) <= 4), ((t % 6) == 4)});
            if ((t % 6) == 4) begin
                model_access(1'b0, 3'd2, hist[t - 4], 32'h0, md, mf);
                exp_dout[2] = md;
                chk("held_data", 2, o_dout[2], md);
                chk("held_fault", 2, {31'b0, o_fault[2]}, 32'h0);
            end
        end
        req_v = '0;

        // Randomized accesses against the model.
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 19);
            rw = 1'($urandom);
            case ($urandom_range(0, 5))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                4: f3 = 3'd5;
                default: f3 = (r < 4) ? 3'(3'd3 + 3'($urandom_range(0, 1)) * 3'd3) : 3'd2;
            endcase
            if (r == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else        a = 32'($urandom_range(0, 255));
            run_access(rw, f3, a, $urandom, 3'b111, 1'b0, 32'h0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
